agen_lsu_buffer: RTL and testbench

//  Collapsing queue between the address-generation FU and the load-store unit (LSU).
//  - Captures each valid FU3 output packet: branch mask, ldst size, flags, dest reg, AL id,

---
 rtl/agen_lsu_buffer_pkg.sv | 35 +++
 rtl/bmask_resolve.sv | 24 ++
 rtl/agen_lsu_buffer.sv | 116 +++++++++++
 tb/tb_agen_lsu_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/agen_lsu_buffer_pkg.sv
// rtl/agen_lsu_buffer_pkg.sv - shared packet field widths and mask position for the AGEN->LSU buffer
package agen_lsu_buffer_pkg;

  localparam int AGEN_CHECKPOINTS     = 4;
  localparam int AGEN_CHECKPOINTS_LOG = 2;

  localparam int SIZE_LDST            = 2;
  localparam int SIZE_FLAGS           = 16;
  localparam int SIZE_PHYSICAL_LOG    = 7;
  localparam int SIZE_ACTIVELIST_LOG  = 8;
  localparam int SIZE_DATA            = 32;
  localparam int SIZE_ISSUEQ_LOG      = 6;
  localparam int SIZE_LSQ_LOG         = 5;
  localparam int SIZE_ADDR            = 32;

  localparam int AGEN_PKT_W = AGEN_CHECKPOINTS + SIZE_LDST + SIZE_FLAGS + SIZE_PHYSICAL_LOG +
                              SIZE_ACTIVELIST_LOG + SIZE_DATA + SIZE_ISSUEQ_LOG +
                              SIZE_LSQ_LOG + SIZE_ADDR;

  localparam int MASK_MSB = AGEN_PKT_W - 1;
  localparam int MASK_LSB = AGEN_PKT_W - AGEN_CHECKPOINTS;

  typedef struct packed {
    logic [AGEN_CHECKPOINTS-1:0]    bmask;
    logic [SIZE_LDST-1:0]           ldst_size;
    logic [SIZE_FLAGS-1:0]          flags;
    logic [SIZE_PHYSICAL_LOG-1:0]   dest_reg;
    logic [SIZE_ACTIVELIST_LOG-1:0] al_id;
    logic [SIZE_DATA-1:0]           st_data;
    logic [SIZE_ISSUEQ_LOG-1:0]     iq_entry;
    logic [SIZE_LSQ_LOG-1:0]        lsq_id;
    logic [SIZE_ADDR-1:0]           addr;
  } agen_pkt_t;

endpackage

// File: rtl/bmask_resolve.sv
// rtl/bmask_resolve.sv - branch resolution for one mask: kill on mispredict, clear bit on correct prediction
module bmask_resolve
  import agen_lsu_buffer_pkg::*;
#(
  parameter int CHECKPOINTS     = AGEN_CHECKPOINTS,
  parameter int CHECKPOINTS_LOG = AGEN_CHECKPOINTS_LOG
) (
  input  logic [CHECKPOINTS-1:0]     mask_i,
  input  logic                       ctrlVerified_i,
  input  logic                       ctrlMispredict_i,
  input  logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_i,
  output logic                       kill_o,
  output logic [CHECKPOINTS-1:0]     mask_o
);

  always_comb begin
    kill_o = ctrlVerified_i & ctrlMispredict_i & mask_i[ctrlSMTid_i];
    mask_o = mask_i;
    if (ctrlVerified_i && !ctrlMispredict_i) begin
      mask_o[ctrlSMTid_i] = 1'b0;
    end
  end

endmodule

// File: rtl/agen_lsu_buffer.sv
// rtl/agen_lsu_buffer.sv - collapsing queue holding AGEN packets until the LSU accepts them
module agen_lsu_buffer
  import agen_lsu_buffer_pkg::*;
#(
  parameter int PKT_W           = AGEN_PKT_W,
  parameter int CHECKPOINTS     = AGEN_CHECKPOINTS,
  parameter int CHECKPOINTS_LOG = AGEN_CHECKPOINTS_LOG,
  parameter int DEPTH           = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PKT_W-1:0]           inPacket_i,
  input  logic                       inValid_i,
  input  logic                       ctrlVerified_i,
  input  logic                       ctrlMispredict_i,
  input  logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_i,
  input  logic                       lsuReady_i,
  output logic [PKT_W-1:0]           outPacket_o,
  output logic                       outValid_o,
  output logic                       stall_o,
  output logic                       overflow_o
);

  localparam int BODY_W = PKT_W - CHECKPOINTS;

  logic [PKT_W-1:0]       entry_q [DEPTH];
  logic [PKT_W-1:0]       entry_d [DEPTH];
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [DEPTH-1:0]       kill;
  logic [CHECKPOINTS-1:0] mask_res [DEPTH];
  logic                   in_kill;
  logic [CHECKPOINTS-1:0] in_mask;
  logic                   stall_q, stall_d;
  logic                   overflow_q, overflow_d;
  logic                   deq;
  int                     pos;

  for (genvar g = 0; g < DEPTH; g++) begin : g_res
    bmask_resolve #(
      .CHECKPOINTS    (CHECKPOINTS),
      .CHECKPOINTS_LOG(CHECKPOINTS_LOG)
    ) u_res (
      .mask_i          (entry_q[g][PKT_W-1 -: CHECKPOINTS]),
      .ctrlVerified_i  (ctrlVerified_i),
      .ctrlMispredict_i(ctrlMispredict_i),
      .ctrlSMTid_i     (ctrlSMTid_i),
      .kill_o          (kill[g]),
      .mask_o          (mask_res[g])
    );
  end

  bmask_resolve #(
    .CHECKPOINTS    (CHECKPOINTS),
    .CHECKPOINTS_LOG(CHECKPOINTS_LOG)
  ) u_res_in (
    .mask_i          (inPacket_i[PKT_W-1 -: CHECKPOINTS]),
    .ctrlVerified_i  (ctrlVerified_i),
    .ctrlMispredict_i(ctrlMispredict_i),
    .ctrlSMTid_i     (ctrlSMTid_i),
    .kill_o          (in_kill),
    .mask_o          (in_mask)
  );

  assign outValid_o  = valid_q[0] & ~kill[0];
  assign outPacket_o = {mask_res[0], entry_q[0][BODY_W-1:0]};
  assign deq         = outValid_o & lsuReady_i;
  assign stall_o     = stall_q;
  assign overflow_o  = overflow_q;

  // Survivors slide down to the lowest free slot in arrival order; the new packet lands after them.
  always_comb begin
    entry_d    = entry_q;
    valid_d    = '0;
    overflow_d = overflow_q;
    pos        = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill[i] && !(i == 0 && deq)) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (pos == j) begin
            entry_d[j] = {mask_res[i], entry_q[i][BODY_W-1:0]};
            valid_d[j] = 1'b1;
          end
        end
        pos = pos + 1;
      end
    end
    if (inValid_i && !in_kill) begin
      if (pos < DEPTH) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (pos == j) begin
            entry_d[j] = {in_mask, inPacket_i[BODY_W-1:0]};
            valid_d[j] = 1'b1;
          end
        end
        pos = pos + 1;
      end else begin
        overflow_d = 1'b1;
      end
    end
    stall_d = (pos == DEPTH);
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    if (!reset) begin
      valid_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_agen_lsu_buffer.sv
// tb/tb_agen_lsu_buffer.sv - directed vectors plus randomized run against a queue-based reference
module tb_agen_lsu_buffer;

  localparam int PW = 112;
  localparam int DEPTH = 2;

  logic          clk;
  logic          reset;
  logic [PW-1:0] inPacket_i;
  logic          inValid_i;
  logic          ctrlVerified_i;
  logic          ctrlMispredict_i;
  logic [1:0]    ctrlSMTid_i;
  logic          lsuReady_i;
  logic [PW-1:0] outPacket_o;
  logic          outValid_o;
  logic          stall_o;
  logic          overflow_o;

  int tests = 0;
  int fails = 0;

  agen_lsu_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .inPacket_i      (inPacket_i),
    .inValid_i       (inValid_i),
    .ctrlVerified_i  (ctrlVerified_i),
    .ctrlMispredict_i(ctrlMispredict_i),
    .ctrlSMTid_i     (ctrlSMTid_i),
    .lsuReady_i      (lsuReady_i),
    .outPacket_o     (outPacket_o),
    .outValid_o      (outValid_o),
    .stall_o         (stall_o),
    .overflow_o      (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        iv;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic        ver;
    logic        mis;
    logic [1:0]  id;
    logic        rdy;
    logic        ev;
    logic [31:0] eaddr;
    logic [3:0]  emask;
    logic        estall;
    logic        eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [PW-1:0] dpkt(input logic [3:0] m, input logic [31:0] a);
    return {m, {19{4'hA}}, a};
  endfunction

  function automatic vec_t mkv(input logic rn, iv, input logic [3:0] m, input logic [31:0] a,
                               input logic ver, mis, input logic [1:0] id, input logic rdy,
                               input logic ev, input logic [31:0] ea, input logic [3:0] em,
                               input logic es, eo);
    vec_t v;
    v.rn = rn; v.iv = iv; v.mask = m; v.addr = a; v.ver = ver; v.mis = mis; v.id = id;
    v.rdy = rdy; v.ev = ev; v.eaddr = ea; v.emask = em; v.estall = es; v.eovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset            = v.rn;
    inValid_i        = v.iv;
    inPacket_i       = dpkt(v.mask, v.addr);
    ctrlVerified_i   = v.ver;
    ctrlMispredict_i = v.mis;
    ctrlSMTid_i      = v.id;
    lsuReady_i       = v.rdy;
    #4;
    chk({tag, ".valid"}, PW'(outValid_o), PW'(v.ev));
    if (v.ev) chk({tag, ".packet"}, outPacket_o, dpkt(v.emask, v.eaddr));
    chk({tag, ".stall"}, PW'(stall_o), PW'(v.estall));
    chk({tag, ".overflow"}, PW'(overflow_o), PW'(v.eovf));
    @(posedge clk);
    #1;
  endtask

  // Reference model: arrival-ordered queue of packets
  logic [PW-1:0] mq[$];
  logic          m_stall, m_ovf;

  function automatic logic m_killed(input logic [PW-1:0] p, input logic ver, mis, input logic [1:0] id);
    return ver & mis & p[108 + int'(id)];
  endfunction

  function automatic logic [PW-1:0] m_clear(input logic [PW-1:0] p, input logic ver, mis, input logic [1:0] id);
    logic [PW-1:0] r;
    r = p;
    if (ver && !mis) r[108 + int'(id)] = 1'b0;
    return r;
  endfunction

  initial begin
    logic [127:0] rnd;
    logic [PW-1:0] nq[$];
    logic exp_v, dq;

    reset = 1'b0; inValid_i = 1'b0; inPacket_i = '0; ctrlVerified_i = 1'b0;
    ctrlMispredict_i = 1'b0; ctrlSMTid_i = '0; lsuReady_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // reset held with valid input, then release
    tbl.push_back(mkv(0,1,4'h0,32'h100,0,0,0,1, 0,0,0,0,0));
    tbl.push_back(mkv(0,1,4'h0,32'h100,0,0,0,1, 0,0,0,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 0,0,0,0,0));
    // streaming
    tbl.push_back(mkv(1,1,4'h0,32'h100,0,0,0,1, 0,0,0,0,0));
    tbl.push_back(mkv(1,1,4'h0,32'h104,0,0,0,1, 1,32'h100,4'h0,0,0));
    tbl.push_back(mkv(1,1,4'h0,32'h108,0,0,0,1, 1,32'h104,4'h0,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h108,4'h0,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 0,0,0,0,0));
    // fill and overflow
    tbl.push_back(mkv(1,1,4'h0,32'h200,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mkv(1,1,4'h0,32'h204,0,0,0,0, 1,32'h200,4'h0,0,0));
    tbl.push_back(mkv(1,1,4'h0,32'h208,0,0,0,0, 1,32'h200,4'h0,1,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h200,4'h0,1,1));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h204,4'h0,0,1));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 0,0,0,0,1));
    // reset clears overflow; then mispredict kill
    tbl.push_back(mkv(0,0,4'h0,32'h0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mkv(1,1,4'b0001,32'h300,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mkv(1,1,4'b0100,32'h304,0,0,0,0, 1,32'h300,4'b0001,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,1,1,0,1, 0,0,0,1,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,0, 1,32'h304,4'b0100,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h304,4'b0100,0,0));
    // correct prediction clears bit in stored and incoming masks
    tbl.push_back(mkv(1,1,4'b0110,32'h400,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mkv(1,1,4'b0100,32'h404,1,0,2,0, 1,32'h400,4'b0010,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,0, 1,32'h400,4'b0010,1,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h400,4'b0010,1,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h404,4'b0000,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 0,0,0,0,0));
    // full: deq head, enqueue D, mispredict kills entry 1
    tbl.push_back(mkv(1,1,4'b0000,32'h500,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mkv(1,1,4'b0010,32'h504,0,0,0,0, 1,32'h500,4'h0,0,0));
    tbl.push_back(mkv(1,1,4'b0000,32'h508,1,1,1,1, 1,32'h500,4'h0,1,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,0, 1,32'h508,4'h0,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h508,4'h0,0,0));
    tbl.push_back(mkv(1,0,4'h0,32'h0,0,0,0,1, 0,0,0,0,0));

    foreach (tbl[k]) apply(tbl[k], $sformatf("v%0d", k));

    // full queue, no deq, kill of both entries frees room for the incoming packet
    apply(mkv(1,1,4'b0001,32'h600,0,0,0,0, 0,0,0,0,0), "kf0");
    apply(mkv(1,1,4'b0001,32'h604,0,0,0,0, 1,32'h600,4'b0001,0,0), "kf1");
    apply(mkv(1,1,4'b0000,32'h608,1,1,0,0, 0,0,0,1,0), "kf2");
    apply(mkv(1,0,4'h0,32'h0,0,0,0,1, 1,32'h608,4'h0,0,0), "kf3");
    apply(mkv(1,0,4'h0,32'h0,0,0,0,1, 0,0,0,0,0), "kf4");

    // randomized run against the reference queue
    apply(mkv(0,0,4'h0,32'h0,0,0,0,0, 0,0,0,0,0), "rreset");
    mq.delete(); m_stall = 1'b0; m_ovf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      reset            = ($urandom_range(0, 49) != 0);
      inValid_i        = ($urandom_range(0, 9) < 7);
      inPacket_i       = rnd[PW-1:0];
      ctrlVerified_i   = ($urandom_range(0, 3) == 0);
      ctrlMispredict_i = $urandom_range(0, 1) == 1;
      ctrlSMTid_i      = 2'($urandom_range(0, 3));
      lsuReady_i       = $urandom_range(0, 1) == 1;
      #4;
      exp_v = (mq.size() > 0) && !m_killed(mq[0], ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i);
      chk($sformatf("r%0d.valid", c), PW'(outValid_o), PW'(exp_v));
      if (exp_v) chk($sformatf("r%0d.packet", c), outPacket_o,
                     m_clear(mq[0], ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i));
      chk($sformatf("r%0d.stall", c), PW'(stall_o), PW'(m_stall));
      chk($sformatf("r%0d.overflow", c), PW'(overflow_o), PW'(m_ovf));
      if (!reset) begin
        mq.delete(); m_stall = 1'b0; m_ovf = 1'b0;
      end else begin
        dq = exp_v && lsuReady_i;
        nq.delete();
        foreach (mq[k]) begin
          if (!m_killed(mq[k], ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i) && !(k == 0 && dq))
            nq.push_back(m_clear(mq[k], ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i));
        end
        if (inValid_i && !m_killed(inPacket_i, ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i)) begin
          if (nq.size() < DEPTH) nq.push_back(m_clear(inPacket_i, ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i));
          else m_ovf = 1'b1;
        end
        mq = nq;
        m_stall = (mq.size() == DEPTH);
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
